// File: rtl/lsu_mem_sequencer_pkg.sv
// rtl/lsu_mem_sequencer_pkg.sv - funct3 constants, sequencer state type and byte-enable helper
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_e;

  // Byte lanes touched by a store of the given size at the given word offset.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      F3_SB:   be = 4'b0001 << offset;
      F3_SH:   be = 4'b0011 << {offset[1], 1'b0};
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_mem_sequencer_if.sv
// rtl/lsu_mem_sequencer_if.sv - request, data-memory and writeback signals of the load/store sequencer
interface lsu_mem_sequencer_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_re;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic [DM_ADDRESS-1:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_misalign;
  logic                  rsp_illegal;

  // Pipeline + memory environment side.
  modport master (
    output req_valid, req_re, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_misalign, rsp_illegal
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_re, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_misalign, rsp_illegal
  );

endinterface

// File: rtl/lsu_mem_sequencer_load_align.sv
// rtl/lsu_mem_sequencer_load_align.sv - selects the addressed byte/half of a read word and extends it
module lsu_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane pick by offset, then sign or zero extension by load kind.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h000000, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// rtl/lsu_mem_sequencer.sv - registers one load/store, issues it to word memory, returns the aligned result
module lsu_mem_sequencer
  import riscv_mem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_sequencer_if.slave  bus
);

  lsu_state_e            state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  logic                  misalign_q, misalign_d;
  logic                  illegal_q, illegal_d;

  logic                  accept;
  logic                  access_ok;
  logic                  illegal_dec;
  logic                  misalign_dec;
  logic [DATA_W-1:0]     store_wdata;
  logic [DATA_W-1:0]     load_result;

  assign bus.req_ready = (state_q != ST_ISSUE);
  assign accept        = bus.req_valid & bus.req_ready;
  assign access_ok     = ~misalign_q & ~illegal_q;

  // Classify the incoming request; illegal wins, so misalign is only raised for legal sizes.
  always_comb begin
    illegal_dec  = 1'b0;
    misalign_dec = 1'b0;
    if (bus.req_re && bus.req_we) begin
      illegal_dec = 1'b1;
    end else if (bus.req_re) begin
      case (bus.req_funct3)
        F3_LB, F3_LBU: misalign_dec = 1'b0;
        F3_LH, F3_LHU: misalign_dec = bus.req_addr[0];
        F3_LW:         misalign_dec = |bus.req_addr[1:0];
        default:       illegal_dec  = 1'b1;
      endcase
    end else if (bus.req_we) begin
      case (bus.req_funct3)
        F3_SB:   misalign_dec = 1'b0;
        F3_SH:   misalign_dec = bus.req_addr[0];
        F3_SW:   misalign_dec = |bus.req_addr[1:0];
        default: illegal_dec  = 1'b1;
      endcase
    end
  end

  // Replicate store data across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    case (funct3_q)
      F3_SB:   store_wdata = {4{wdata_q[7:0]}};
      F3_SH:   store_wdata = {2{wdata_q[15:0]}};
      default: store_wdata = wdata_q;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata  (bus.mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (load_result)
  );

  // Next state, request capture, memory strobes and the one-cycle writeback pulse.
  always_comb begin
    state_d          = state_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    re_d             = re_q;
    we_d             = we_q;
    misalign_d       = misalign_q;
    illegal_d        = illegal_q;
    bus.mem_re       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_be       = 4'b0000;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = '0;
    bus.rsp_misalign = 1'b0;
    bus.rsp_illegal  = 1'b0;

    if (accept) begin
      funct3_d   = bus.req_funct3;
      addr_d     = bus.req_addr;
      wdata_d    = bus.req_wdata;
      re_d       = bus.req_re;
      we_d       = bus.req_we;
      misalign_d = misalign_dec;
      illegal_d  = illegal_dec;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (access_ok) begin
          bus.mem_re   = re_q;
          bus.mem_we   = we_q;
          bus.mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
          if (we_q) begin
            bus.mem_be    = store_be(funct3_q, addr_q[1:0]);
            bus.mem_wdata = store_wdata;
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid    = 1'b1;
        bus.rsp_illegal  = illegal_q;
        bus.rsp_misalign = misalign_q & ~illegal_q;
        if (re_q && access_ok) bus.rsp_rdata = load_result;
        state_d = accept ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset drops any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      re_q       <= re_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb/tb_lsu_mem_sequencer.sv - vector table, back-to-back, random and reset checks for lsu_mem_sequencer
module tb_lsu_mem_sequencer;
  import riscv_mem_pkg::*;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wd;
  } op_t;

  typedef struct packed {
    logic        do_re;
    logic        do_we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
  } exp_t;

  typedef struct packed {
    op_t         op;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
  } vec_t;

  logic        clk;
  logic        rst_n;
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] phys_mem [128];
  logic [31:0] ref_mem  [128];
  logic [31:0] rd_q;
  vec_t        tbl [24];

  lsu_mem_sequencer_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  lsu_mem_sequencer #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  assign bus.mem_rdata = rd_q;

  initial begin
    rd_q <= 32'h0;
    for (int i = 0; i < 128; i++) phys_mem[i] <= 32'h0;
  end

  always @(posedge clk) begin
    if (bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) phys_mem[bus.mem_addr[8:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    if (bus.mem_re) rd_q <= phys_mem[bus.mem_addr[8:2]];
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input logic re, input logic we, input logic [2:0] f3,
                                 input logic [8:0] addr, input logic [31:0] wd,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic mis, input logic ill);
    vec_t v;
    v.op.re = re; v.op.we = we; v.op.f3 = f3; v.op.addr = addr; v.op.wd = wd;
    v.be = be; v.wdata = wdata; v.rdata = rdata; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  // Reference: size from funct3, fault rules, lane arithmetic on a byte-addressed view of ref_mem.
  function automatic exp_t predict(input op_t op);
    exp_t        e;
    int          nbytes;
    int          off;
    logic [31:0] word;
    logic [31:0] mask;
    logic [31:0] v;
    e      = '0;
    nbytes = 1 << op.f3[1:0];
    off    = int'(op.addr[1:0]);
    e.ill  = (op.re && op.we) ||
             (op.re && (op.f3 == 3'd3 || op.f3 == 3'd6 || op.f3 == 3'd7)) ||
             (op.we && op.f3 > 3'd2);
    e.mis  = !e.ill && (op.re || op.we) && ((int'(op.addr) % nbytes) != 0);
    if (!e.ill && !e.mis) begin
      word = ref_mem[op.addr[8:2]];
      if (op.re) begin
        e.do_re = 1'b1;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        v = (word >> (8 * off)) & mask;
        if (!op.f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v - (32'd1 << (8 * nbytes));
        e.rdata = v;
      end else if (op.we) begin
        e.do_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
          e.wdata[8*i +: 8] = op.wd[8*(i % nbytes) +: 8];
          if (i >= off && i < off + nbytes) e.be[i] = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic commit(input op_t op, input exp_t e);
    if (e.do_we)
      for (int i = 0; i < 4; i++)
        if (e.be[i]) ref_mem[op.addr[8:2]][8*i +: 8] = e.wdata[8*i +: 8];
  endtask

  task automatic drive(input op_t op);
    bus.req_re     = op.re;
    bus.req_we     = op.we;
    bus.req_funct3 = op.f3;
    bus.req_addr   = op.addr;
    bus.req_wdata  = op.wd;
  endtask

  task automatic check_issue(input string tag, input op_t op, input exp_t e);
    chk1($sformatf("%s ready_issue", tag), bus.req_ready, 1'b0);
    chk1($sformatf("%s rsp_valid_issue", tag), bus.rsp_valid, 1'b0);
    chk1($sformatf("%s mem_re", tag), bus.mem_re, e.do_re);
    chk1($sformatf("%s mem_we", tag), bus.mem_we, e.do_we);
    chk32($sformatf("%s mem_be", tag), {28'd0, bus.mem_be}, {28'd0, e.be});
    if (e.do_re || e.do_we)
      chk32($sformatf("%s mem_addr", tag), {23'd0, bus.mem_addr}, {23'd0, op.addr & 9'h1FC});
    if (e.do_we) chk32($sformatf("%s mem_wdata", tag), bus.mem_wdata, e.wdata);
  endtask

  task automatic check_resp(input string tag, input exp_t e);
    chk1($sformatf("%s rsp_valid", tag), bus.rsp_valid, 1'b1);
    chk1($sformatf("%s ready_resp", tag), bus.req_ready, 1'b1);
    chk1($sformatf("%s strobes_resp", tag), bus.mem_re | bus.mem_we, 1'b0);
    chk32($sformatf("%s rsp_rdata", tag), bus.rsp_rdata, e.rdata);
    chk1($sformatf("%s rsp_misalign", tag), bus.rsp_misalign, e.mis);
    chk1($sformatf("%s rsp_illegal", tag), bus.rsp_illegal, e.ill);
  endtask

  // One op from idle: accept, ISSUE checks, RESP checks; observed values returned for table compares.
  task automatic run_op(input op_t op, input string tag,
                        output logic [3:0] o_be, output logic [31:0] o_wd,
                        output logic [31:0] o_rd, output logic o_mis, output logic o_ill);
    exp_t e;
    e = predict(op);
    drive(op);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_issue(tag, op, e);
    o_be = bus.mem_be;
    o_wd = bus.mem_wdata;
    @(posedge clk);
    @(negedge clk);
    check_resp(tag, e);
    o_rd  = bus.rsp_rdata;
    o_mis = bus.rsp_misalign;
    o_ill = bus.rsp_illegal;
    commit(op, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_rd, old_word;
    logic        o_mis, o_ill;
    op_t         op;
    op_t         b2b [4];
    exp_t        e;
    int          kind;
    int          bad_words;

    for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;

    tbl[0]  = mkvec(1'b0, 1'b1, 3'd2, 9'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    tbl[1]  = mkvec(1'b1, 1'b0, 3'd2, 9'h010, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    tbl[2]  = mkvec(1'b0, 1'b1, 3'd0, 9'h013, 32'h000000A5, 4'h8, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
    tbl[3]  = mkvec(1'b1, 1'b0, 3'd0, 9'h013, 32'h0, 4'h0, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b0);
    tbl[4]  = mkvec(1'b1, 1'b0, 3'd4, 9'h013, 32'h0, 4'h0, 32'h0, 32'h000000A5, 1'b0, 1'b0);
    tbl[5]  = mkvec(1'b0, 1'b1, 3'd1, 9'h022, 32'h00008001, 4'hC, 32'h80018001, 32'h0, 1'b0, 1'b0);
    tbl[6]  = mkvec(1'b1, 1'b0, 3'd1, 9'h022, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    tbl[7]  = mkvec(1'b1, 1'b0, 3'd5, 9'h022, 32'h0, 4'h0, 32'h0, 32'h00008001, 1'b0, 1'b0);
    tbl[8]  = mkvec(1'b1, 1'b0, 3'd2, 9'h021, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[9]  = mkvec(1'b0, 1'b1, 3'd1, 9'h023, 32'h00001234, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[10] = mkvec(1'b1, 1'b0, 3'd3, 9'h010, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tbl[11] = mkvec(1'b1, 1'b1, 3'd2, 9'h010, 32'h11111111, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tbl[12] = mkvec(1'b1, 1'b0, 3'd2, 9'h010, 32'h0, 4'h0, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b0);
    tbl[13] = mkvec(1'b0, 1'b0, 3'd2, 9'h010, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[14] = mkvec(1'b0, 1'b1, 3'd3, 9'h010, 32'h22222222, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tbl[15] = mkvec(1'b1, 1'b0, 3'd2, 9'h020, 32'h0, 4'h0, 32'h0, 32'h80010000, 1'b0, 1'b0);
    tbl[16] = mkvec(1'b1, 1'b0, 3'd0, 9'h022, 32'h0, 4'h0, 32'h0, 32'h00000001, 1'b0, 1'b0);
    tbl[17] = mkvec(1'b1, 1'b0, 3'd0, 9'h023, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    tbl[18] = mkvec(1'b1, 1'b0, 3'd5, 9'h011, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[19] = mkvec(1'b0, 1'b1, 3'd2, 9'h012, 32'h33333333, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[20] = mkvec(1'b1, 1'b0, 3'd1, 9'h012, 32'h0, 4'h0, 32'h0, 32'hFFFFA5AD, 1'b0, 1'b0);
    tbl[21] = mkvec(1'b1, 1'b0, 3'd7, 9'h011, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tbl[22] = mkvec(1'b0, 1'b1, 3'd4, 9'h013, 32'h44444444, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tbl[23] = mkvec(1'b1, 1'b0, 3'd2, 9'h010, 32'h0, 4'h0, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b0);

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    op            = '0;
    drive(op);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset req_ready", bus.req_ready, 1'b1);
    chk1("reset mem_re", bus.mem_re, 1'b0);
    chk1("reset mem_we", bus.mem_we, 1'b0);
    chk32("reset mem_be", {28'd0, bus.mem_be}, 32'h0);
    chk32("reset mem_addr", {23'd0, bus.mem_addr}, 32'h0);
    chk32("reset mem_wdata", bus.mem_wdata, 32'h0);
    chk1("reset rsp_valid", bus.rsp_valid, 1'b0);
    chk32("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("reset rsp_misalign", bus.rsp_misalign, 1'b0);
    chk1("reset rsp_illegal", bus.rsp_illegal, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 24; k++) begin
      run_op(tbl[k].op, $sformatf("vec%0d", k), o_be, o_wd, o_rd, o_mis, o_ill);
      chk32($sformatf("vec%0d tbl_be", k), {28'd0, o_be}, {28'd0, tbl[k].be});
      if (tbl[k].be != 4'h0) chk32($sformatf("vec%0d tbl_wdata", k), o_wd, tbl[k].wdata);
      chk32($sformatf("vec%0d tbl_rdata", k), o_rd, tbl[k].rdata);
      chk1($sformatf("vec%0d tbl_mis", k), o_mis, tbl[k].mis);
      chk1($sformatf("vec%0d tbl_ill", k), o_ill, tbl[k].ill);
    end

    // Back-to-back with req_valid held: one response every two cycles.
    b2b[0] = '{re: 1'b0, we: 1'b1, f3: 3'd2, addr: 9'h040, wd: 32'h12345678};
    b2b[1] = '{re: 1'b1, we: 1'b0, f3: 3'd2, addr: 9'h040, wd: 32'h0};
    b2b[2] = '{re: 1'b0, we: 1'b1, f3: 3'd0, addr: 9'h041, wd: 32'h0000009A};
    b2b[3] = '{re: 1'b1, we: 1'b0, f3: 3'd2, addr: 9'h040, wd: 32'h0};
    drive(b2b[0]);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = predict(b2b[k]);
      @(posedge clk);
      #1;
      if (k < 3) drive(b2b[k+1]);
      else bus.req_valid = 1'b0;
      @(negedge clk);
      check_issue($sformatf("b2b%0d", k), b2b[k], e);
      @(posedge clk);
      @(negedge clk);
      check_resp($sformatf("b2b%0d", k), e);
      commit(b2b[k], e);
    end
    chk32("b2b final word", ref_mem[9'h040 >> 2], 32'h12349A78);
    @(posedge clk);
    @(negedge clk);
    chk1("b2b idle rsp_valid", bus.rsp_valid, 1'b0);
    chk1("b2b idle ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 200; k++) begin
      kind    = int'($urandom_range(0, 7));
      op.re   = (kind <= 2) || (kind == 7);
      op.we   = (kind >= 3 && kind <= 5) || (kind == 7);
      op.f3   = 3'($urandom_range(0, 7));
      op.addr = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 2) == 0) op.addr[1:0] = 2'b00;
      op.wd   = $urandom;
      run_op(op, $sformatf("rnd%0d", k), o_be, o_wd, o_rd, o_mis, o_ill);
    end

    // Reset during ISSUE of a store: strobe drops at once and the word is untouched.
    old_word = ref_mem[9'h080 >> 2];
    op = '{re: 1'b0, we: 1'b1, f3: 3'd2, addr: 9'h080, wd: 32'hCAFEF00D};
    drive(op);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #1 chk1("rst_mid mem_we before", bus.mem_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_mid mem_we", bus.mem_we, 1'b0);
    chk32("rst_mid mem_be", {28'd0, bus.mem_be}, 32'h0);
    chk1("rst_mid rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_mid ready", bus.req_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_after rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_after ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    op = '{re: 1'b1, we: 1'b0, f3: 3'd2, addr: 9'h080, wd: 32'h0};
    run_op(op, "rst_readback", o_be, o_wd, o_rd, o_mis, o_ill);
    chk32("rst_readback word", o_rd, old_word);

    bad_words = 0;
    for (int i = 0; i < 128; i++)
      if (phys_mem[i] !== ref_mem[i]) bad_words++;
    chk32("memory image bad words", 32'(bad_words), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
